// File: rtl/seq_pattern_detector_if.sv
// Serial bit-stream interface for seq_pattern_detector.
//   in_valid : in_bit carries a data bit this cycle
//   in_bit   : serial data bit
// master drives the stream; slave (the detector) consumes it.
interface seq_pattern_detector_if;
  logic in_valid;
  logic in_bit;

  modport master (output in_valid, output in_bit);
  modport slave  (input  in_valid, input  in_bit);
endinterface

// File: rtl/seq_pattern_detector.sv
// Serial bit-stream pattern detector with programmable pattern/length,
// overlap / non-overlap modes, registered match pulse and saturating counter.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   en           : enable; raising it arms the detector and latches the config
//   cfg_pattern  : pattern, bit [len-1] is the first bit received
//   cfg_len      : pattern length, clamped to 1..MAX_LEN when latched
//   cfg_overlap  : 1 = overlapping matches, 0 = restart after each match
//   cnt_clr      : synchronous clear of match_cnt
//   stream       : serial input (in_valid, in_bit)
//   match        : one-cycle pulse, pattern completed by the last accepted bit
//   match_cnt    : saturating count of match pulses
//   busy         : detector is armed (state != IDLE)
module seq_pattern_detector #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [MAX_LEN-1:0]     cfg_pattern,
  input  logic [LEN_W-1:0]       cfg_len,
  input  logic                   cfg_overlap,
  input  logic                   cnt_clr,
  seq_pattern_detector_if.slave  stream,
  output logic                   match,
  output logic [CNT_W-1:0]       match_cnt,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [MAX_LEN-1:0]   pat_q, pat_n;
  logic [LEN_W-1:0]     len_q, len_n;
  logic                 ovl_q, ovl_n;
  // Only the MAX_LEN-1 most recent bits need storing: together with the
  // incoming bit they form the full MAX_LEN compare window.
  logic [MAX_LEN-2:0]   hist, hist_n;
  logic [LEN_W-1:0]     fill, fill_n, fill_inc;
  logic [MAX_LEN-1:0]   window;
  logic                 accept;
  logic                 cmp;
  logic                 hit;
  logic                 match_p1;
  logic [CNT_W-1:0]     cnt_p1;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0) return LEN_W'(1);
    if (l > LEN_W'(MAX_LEN)) return LEN_W'(MAX_LEN);
    return l;
  endfunction

  // Ones in the low l bits: bits at or above the pattern length are ignored.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [MAX_LEN-1:0] m;
    for (int i = 0; i < MAX_LEN; i++) m[i] = (LEN_W'(i) < l);
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic inc);
    if (inc && (c != '1)) return c + 1'b1;
    return c;
  endfunction

  assign window   = {hist, stream.in_bit};
  assign fill_inc = fill + 1'b1;
  assign accept   = stream.in_valid && (state != IDLE);
  assign cmp      = (((window ^ pat_q) & len_mask(len_q)) == '0);

  always_comb begin
    state_n = state;
    pat_n   = pat_q;
    len_n   = len_q;
    ovl_n   = ovl_q;
    hist_n  = hist;
    fill_n  = fill;
    hit     = 1'b0;
    if (!en) begin
      // Dropping en discards any bit offered this cycle.
      state_n = IDLE;
      hist_n  = '0;
      fill_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          pat_n   = cfg_pattern;
          len_n   = clamp_len(cfg_len);
          ovl_n   = cfg_overlap;
          fill_n  = '0;
          state_n = FILL;
        end
        FILL: begin
          if (accept) begin
            hist_n = window[MAX_LEN-2:0];
            if (fill_inc >= len_q) begin
              hit = cmp;
              if (hit && !ovl_q) begin
                fill_n = '0;
              end else begin
                fill_n  = fill_inc;
                state_n = HUNT;
              end
            end else begin
              fill_n = fill_inc;
            end
          end
        end
        HUNT: begin
          if (accept) begin
            hist_n = window[MAX_LEN-2:0];
            hit    = cmp;
            // Non-overlap: the next match must be built from len fresh bits.
            if (hit && !ovl_q) begin
              fill_n  = '0;
              state_n = FILL;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Stage p1: state, history and registered match / counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      ovl_q    <= 1'b0;
      hist     <= '0;
      fill     <= '0;
      match_p1 <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      state    <= state_n;
      pat_q    <= pat_n;
      len_q    <= len_n;
      ovl_q    <= ovl_n;
      hist     <= hist_n;
      fill     <= fill_n;
      match_p1 <= hit;
      // Counter moves on the same edge the match pulse appears; a
      // coincident clear wins first, then the new match is counted.
      cnt_p1   <= cnt_clr ? CNT_W'(hit) : sat_inc(cnt_p1, hit);
    end
  end

  assign match     = match_p1;
  assign match_cnt = cnt_p1;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_pattern_detector.sv
module tb_seq_pattern_detector;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       match, match2, busy, busy2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int errors = 0;
  int checks = 0;

  seq_pattern_detector_if sif ();

  seq_pattern_detector #(.MAX_LEN(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .stream(sif), .match(match), .match_cnt(match_cnt), .busy(busy));

  seq_pattern_detector #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .stream(sif), .match(match2), .match_cnt(match_cnt2), .busy(busy2));

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       vld;
    logic       b;
    logic       clr;
    logic       em;
    logic [7:0] ecnt;
    logic       eb;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic e, input logic [7:0] p, input logic [3:0] l,
                     input logic o, input logic v, input logic b, input logic c,
                     input logic em, input logic [7:0] ec, input logic eb);
    vec_t x;
    x.en = e; x.pat = p; x.len = l; x.ovl = o; x.vld = v; x.b = b; x.clr = c;
    x.em = em; x.ecnt = ec; x.eb = eb;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the consuming edge.
  task automatic cyc(input logic e, input logic [7:0] p, input logic [3:0] l,
                     input logic o, input logic v, input logic b, input logic c);
    en = e; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    sif.in_valid = v; sif.in_bit = b; cnt_clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    sif.in_valid = 1'b0;
    sif.in_bit   = 1'b0;

    // Overlap, 101
    add(1,8'h05,3,1, 0,0,0, 0,0,1);
    add(1,8'h05,3,1, 1,1,0, 0,0,1);
    add(1,8'h05,3,1, 1,0,0, 0,0,1);
    add(1,8'h05,3,1, 1,1,0, 1,1,1);
    add(1,8'h05,3,1, 1,0,0, 0,1,1);
    add(1,8'h05,3,1, 1,1,0, 1,2,1);
    add(0,8'h05,3,1, 0,0,0, 0,2,0);
    // Non-overlap, 101, then 1,0,1
    add(1,8'h05,3,0, 0,0,0, 0,2,1);
    add(1,8'h05,3,0, 1,1,0, 0,2,1);
    add(1,8'h05,3,0, 1,0,0, 0,2,1);
    add(1,8'h05,3,0, 1,1,0, 1,3,1);
    add(1,8'h05,3,0, 1,0,0, 0,3,1);
    add(1,8'h05,3,0, 1,1,0, 0,3,1);
    add(1,8'h05,3,0, 1,1,0, 0,3,1);
    add(1,8'h05,3,0, 1,0,0, 0,3,1);
    add(1,8'h05,3,0, 1,1,0, 1,4,1);
    add(0,8'h05,3,0, 0,0,0, 0,4,0);
    // Legacy two-ones: 1,1,1,0,1,1
    add(1,8'h03,2,1, 0,0,0, 0,4,1);
    add(1,8'h03,2,1, 1,1,0, 0,4,1);
    add(1,8'h03,2,1, 1,1,0, 1,5,1);
    add(1,8'h03,2,1, 1,1,0, 1,6,1);
    add(1,8'h03,2,1, 1,0,0, 0,6,1);
    add(1,8'h03,2,1, 1,1,0, 0,6,1);
    add(1,8'h03,2,1, 1,1,0, 1,7,1);
    add(0,8'h03,2,1, 0,0,0, 0,7,0);
    // len=0 -> 1 with pat[0]=0; pattern change while busy ignored
    add(1,8'hFE,0,1, 0,0,0, 0,7,1);
    add(1,8'hFE,0,1, 1,0,0, 1,8,1);
    add(1,8'hFE,0,1, 1,1,0, 0,8,1);
    add(1,8'hFE,0,1, 1,0,0, 1,9,1);
    add(1,8'hFF,0,1, 1,0,0, 1,10,1);
    add(0,8'hFF,0,1, 0,0,0, 0,10,0);
    // len=12 -> 8, pattern A5
    add(1,8'hA5,12,1, 0,0,0, 0,10,1);
    add(1,8'hA5,12,1, 1,1,0, 0,10,1);
    add(1,8'hA5,12,1, 1,0,0, 0,10,1);
    add(1,8'hA5,12,1, 1,1,0, 0,10,1);
    add(1,8'hA5,12,1, 1,0,0, 0,10,1);
    add(1,8'hA5,12,1, 1,0,0, 0,10,1);
    add(1,8'hA5,12,1, 1,1,0, 0,10,1);
    add(1,8'hA5,12,1, 1,0,0, 0,10,1);
    add(1,8'hA5,12,1, 1,1,0, 1,11,1);
    add(0,8'hA5,12,1, 0,0,0, 0,11,0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.match", match, 0);
    chk("rst.cnt", match_cnt, 0);
    chk("rst.busy", busy, 0);
    rst_n = 1'b1;
    cyc(0,8'h00,0,0, 0,0,0);
    chk("idle.busy", busy, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].en, tbl[i].pat, tbl[i].len, tbl[i].ovl, tbl[i].vld, tbl[i].b, tbl[i].clr);
      chk($sformatf("v%0d.match", i), match, tbl[i].em);
      chk($sformatf("v%0d.cnt", i), match_cnt, tbl[i].ecnt);
      chk($sformatf("v%0d.busy", i), busy, tbl[i].eb);
    end

    // Two-ones stream with 0..5 idle cycles before each bit
    begin
      logic [5:0] bits;
      logic [5:0] exp_m;
      bits  = 6'b110111;   // bit i of this vector is the i-th bit sent
      exp_m = 6'b100110;
      cyc(1,8'h03,2,1, 0,0,0);
      for (int i = 0; i < 6; i++) begin
        for (int g = 0; g < i; g++) begin
          cyc(1,8'h03,2,1, 0,0,0);
          chk($sformatf("gap%0d_%0d.match", i, g), match, 0);
        end
        cyc(1,8'h03,2,1, 1,bits[i],0);
        chk($sformatf("gapbit%0d.match", i), match, exp_m[i]);
      end
      cyc(0,8'h03,2,1, 0,0,0);
    end

    // Saturating 2-bit counter, len=1 non-overlap, clear coincident with a match
    cyc(1,8'h01,1,0, 0,0,1);
    chk("sat.clr", match_cnt2, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(1,8'h01,1,0, 1,1,0);
      chk($sformatf("sat%0d.match", k), match2, 1);
      chk($sformatf("sat%0d.cnt", k), match_cnt2, (k < 3) ? k + 1 : 3);
    end
    cyc(1,8'h01,1,0, 1,1,1);
    chk("satclr.match", match2, 1);
    chk("satclr.cnt", match_cnt2, 1);
    chk("satclr.cnt8", match_cnt, 1);
    cyc(1,8'h01,1,0, 1,0,0);
    chk("sat0.match", match2, 0);
    cyc(0,8'h01,1,0, 0,0,0);

    // en dropped mid-pattern, completing bit offered on the drop cycle
    cyc(1,8'h05,3,1, 0,0,0);
    cyc(1,8'h05,3,1, 1,1,0);
    cyc(1,8'h05,3,1, 1,0,0);
    cyc(0,8'h05,3,1, 1,1,0);
    chk("drop.match", match, 0);
    chk("drop.busy", busy, 0);
    cyc(1,8'h05,3,1, 0,0,0);
    chk("rearm.busy", busy, 1);
    cyc(1,8'h05,3,1, 1,1,0);
    chk("lone.match", match, 0);
    chk("lone.cnt", match_cnt, 1);
    cyc(0,8'h05,3,1, 0,0,0);

    // Same, with an asynchronous reset pulse mid-pattern
    cyc(1,8'h05,3,1, 0,0,0);
    cyc(1,8'h05,3,1, 1,1,0);
    cyc(1,8'h05,3,1, 1,0,0);
    sif.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("arst.match", match, 0);
    chk("arst.busy", busy, 0);
    chk("arst.cnt", match_cnt, 0);
    chk("arst.cnt2", match_cnt2, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1,8'h05,3,1, 0,0,0);
    cyc(1,8'h05,3,1, 1,1,0);
    chk("arst.lone.match", match, 0);
    chk("arst.lone.cnt", match_cnt, 0);
    cyc(0,8'h05,3,1, 0,0,0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
